// File: rtl/uart_rx_checker_if.sv
// Serial link bundle between a UART line source and the receive checker.
// The master drives rx; the slave returns the received byte, pulses and counters.
interface uart_rx_checker_if;
  logic        rx;
  logic [7:0]  data;
  logic        valid;
  logic        frame_err;
  logic [15:0] good_cnt;
  logic [7:0]  err_cnt;

  modport master (
    output rx,
    input  data, valid, frame_err, good_cnt, err_cnt
  );

  modport slave (
    input  rx,
    output data, valid, frame_err, good_cnt, err_cnt
  );
endinterface

// File: rtl/uart_rx_checker.sv
// 8N1 UART receiver with framing-error detection and saturating link counters.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchronizer (adds 2 cycles).
module uart_rx_checker #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_checker_if.slave bus
);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          rx_prev;
  logic          rx_line;
  logic          mid;
  logic          last;

  logic [7:0]    data_q;
  logic          valid_q;
  logic          frame_err_q;
  logic [15:0]   good_q;
  logic [7:0]    err_q;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;

  // Metastability guard for an off-board source; idles high out of reset.
  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], bus.rx};
  end
  assign rx_line = sync[1];
`else
  assign rx_line = bus.rx;
`endif

  assign mid  = (cnt == CNT_HALF);
  assign last = (cnt == CNT_LAST);

  // Frame FSM: mid-bit sampling, one-cycle pulses and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      rx_prev     <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      good_q      <= '0;
      err_q       <= '0;
    end else begin
      rx_prev     <= rx_line;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_line && rx_prev) begin
            bit_idx <= '0;
            if (HALF == 0) begin
              state <= DATA;
            end else begin
              state <= START;
              cnt   <= CNT_ONE;
            end
          end
        end
        START: begin
          if (mid && rx_line) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (last) begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        DATA: begin
          if (mid) shift[bit_idx] <= rx_line;
          if (last) begin
            cnt <= '0;
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STOP: begin
          if (mid) begin
            if (rx_line) begin
              data_q  <= shift;
              valid_q <= 1'b1;
              good_q  <= (good_q == 16'hFFFF) ? good_q : good_q + 16'd1;
            end else begin
              frame_err_q <= 1'b1;
              err_q       <= (err_q == 8'hFF) ? err_q : err_q + 8'd1;
            end
          end
          // IDLE by the last stop cycle so a zero-gap start bit is still seen.
          if (last) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.good_cnt  = good_q;
  assign bus.err_cnt   = err_q;

endmodule

// File: tb/tb_uart_rx_checker.sv
// Bench for uart_rx_checker: two instances (1 and 16 clocks per bit) against a
// frame-level reference model, plus directed scenarios with literal expectations.
module tb_uart_rx_checker;
`ifdef UART_RX_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int CPB0 = 1;
  localparam int CPB1 = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxv [2];

  always #5 clk = ~clk;

  uart_rx_checker_if bus0 ();
  uart_rx_checker_if bus1 ();

  assign bus0.rx = rxv[0];
  assign bus1.rx = rxv[1];

  uart_rx_checker #(.CLKS_PER_BIT(CPB0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  uart_rx_checker #(.CLKS_PER_BIT(CPB1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  logic [7:0]  o_data  [2];
  logic        o_valid [2];
  logic        o_ferr  [2];
  logic [15:0] o_good  [2];
  logic [7:0]  o_err   [2];
  assign o_data[0] = bus0.data;     assign o_data[1] = bus1.data;
  assign o_valid[0] = bus0.valid;   assign o_valid[1] = bus1.valid;
  assign o_ferr[0] = bus0.frame_err; assign o_ferr[1] = bus1.frame_err;
  assign o_good[0] = bus0.good_cnt; assign o_good[1] = bus1.good_cnt;
  assign o_err[0] = bus0.err_cnt;   assign o_err[1] = bus1.err_cnt;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  bit started = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
  endtask

  // Reference model: per-cycle history of the effective line, frames decoded by offset.
  int  cpbv  [2] = '{CPB0, CPB1};
  bit  hist  [2][256];
  int  mcyc  [2];
  int  fstart[2];
  int  nfree [2];
  bit  mprev [2];
  bit  d0 [2];
  bit  d1 [2];
  logic [7:0] e_data [2];
  bit  e_valid [2];
  bit  e_ferr  [2];
  int  e_good  [2];
  int  e_err   [2];

  task automatic model_step(input int k);
    bit eff;
    int c, off, half, cpb;
    logic [7:0] b;
    cpb  = cpbv[k];
    half = cpb / 2;
    if (rst) begin
      mcyc[k] = 0; fstart[k] = -1; nfree[k] = 0; mprev[k] = 1'b0;
      d0[k] = 1'b1; d1[k] = 1'b1;
      e_data[k] = 8'h00; e_valid[k] = 1'b0; e_ferr[k] = 1'b0;
      e_good[k] = 0; e_err[k] = 0;
    end else begin
`ifdef UART_RX_SYNC_EN
      eff = d1[k]; d1[k] = d0[k]; d0[k] = rxv[k];
`else
      eff = rxv[k];
`endif
      c = mcyc[k];
      hist[k][c % 256] = eff;
      e_valid[k] = 1'b0;
      e_ferr[k]  = 1'b0;
      if (fstart[k] < 0 && c >= nfree[k] && !eff && mprev[k]) fstart[k] = c;
      if (fstart[k] >= 0) begin
        off = c - fstart[k];
        if (half > 0 && off == half && eff) begin
          fstart[k] = -1;
          nfree[k]  = c + 1;
        end else if (off == 9 * cpb + half) begin
          for (int i = 0; i < 8; i++) b[i] = hist[k][(fstart[k] + (i + 1) * cpb + half) % 256];
          if (eff) begin
            e_valid[k] = 1'b1;
            e_data[k]  = b;
            if (e_good[k] < 65535) e_good[k]++;
          end else begin
            e_ferr[k] = 1'b1;
            if (e_err[k] < 255) e_err[k]++;
          end
          nfree[k]  = fstart[k] + 10 * cpb;
          fstart[k] = -1;
        end
      end
      mprev[k] = eff;
      mcyc[k]  = c + 1;
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int k = 0; k < 2; k++) model_step(k);
    started = 1'b1;
  end

  // Per-cycle compare against the model, plus pulse bookkeeping for directed checks.
  int vcnt [2] = '{0, 0};
  int vq0 [$];
  int vq1 [$];

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk(k == 0 ? "c1_data"  : "c16_data",  int'(o_data[k]),  int'(e_data[k]));
        chk(k == 0 ? "c1_valid" : "c16_valid", int'(o_valid[k]), int'(e_valid[k]));
        chk(k == 0 ? "c1_ferr"  : "c16_ferr",  int'(o_ferr[k]),  int'(e_ferr[k]));
        chk(k == 0 ? "c1_good"  : "c16_good",  int'(o_good[k]),  e_good[k]);
        chk(k == 0 ? "c1_err"   : "c16_err",   int'(o_err[k]),   e_err[k]);
      end
    end
    if (o_valid[0] === 1'b1) begin vcnt[0]++; vq0.push_back(cyc); end
    if (o_valid[1] === 1'b1) begin vcnt[1]++; vq1.push_back(cyc); end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic hold(input int k, input bit v, input int n);
    rxv[k] = v;
    step(n);
  endtask

  task automatic frame(input int k, input logic [7:0] b, input bit stop);
    hold(k, 1'b0, cpbv[k]);
    for (int i = 0; i < 8; i++) hold(k, b[i], cpbv[k]);
    hold(k, stop, cpbv[k]);
  endtask

  task automatic rand_traffic(input int k, input int nframes);
    repeat (nframes) begin
      if ($urandom_range(0, 5) == 0) begin
        hold(k, 1'b0, int'($urandom_range(1, cpbv[k])));
        hold(k, 1'b1, int'($urandom_range(1, 3)));
      end
      frame(k, 8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0);
      hold(k, 1'b1, int'($urandom_range(0, 3)));
    end
    repeat (300) hold(k, 1'($urandom_range(0, 1)), 1);
    hold(k, 1'b1, 200);
  endtask

  int fall, vbase, lat;

  initial begin
    rxv[0] = 1'b1;
    rxv[1] = 1'b1;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    chk("reset_good", int'(o_good[0]), 0);
    chk("reset_data", int'(o_data[1]), 0);
    step(2);

    // Back-to-back 0xAA frames at one bit per clock.
    vq0.delete();
    repeat (3) frame(0, 8'hAA, 1'b1);
    hold(0, 1'b1, 3 + SL);
    chk("b2b_good_cnt", int'(o_good[0]), 3);
    chk("b2b_data", int'(o_data[0]), 8'hAA);
    chk("b2b_err_cnt", int'(o_err[0]), 0);
    chk("b2b_pulses", vq0.size(), 3);
    if (vq0.size() == 3) begin
      chk("b2b_spacing_a", vq0[1] - vq0[0], 10);
      chk("b2b_spacing_b", vq0[2] - vq0[1], 10);
    end

    // Single 0x5A at 16 clocks per bit: latency from falling edge.
    vq1.delete();
    fall = cyc;
    frame(1, 8'h5A, 1'b1);
    hold(1, 1'b1, 20);
    lat = (vq1.size() > 0) ? vq1[0] - fall : -1;
    chk("lat16", lat, 153 + SL);
    chk("lat16_data", int'(o_data[1]), 8'h5A);

    // Bad stop bit: error counted, data held.
    vbase = vcnt[1];
    frame(1, 8'h3C, 1'b0);
    hold(1, 1'b1, 20);
    chk("ferr_err_cnt", int'(o_err[1]), 1);
    chk("ferr_data_held", int'(o_data[1]), 8'h5A);
    chk("ferr_no_valid", vcnt[1] - vbase, 0);

    // Short glitch rejected, then a clean 0x81.
    vbase = vcnt[1];
    hold(1, 1'b0, 4);
    hold(1, 1'b1, 30);
    chk("glitch_no_valid", vcnt[1] - vbase, 0);
    chk("glitch_err_cnt", int'(o_err[1]), 1);
    frame(1, 8'h81, 1'b1);
    hold(1, 1'b1, 20);
    chk("glitch_next_data", int'(o_data[1]), 8'h81);
    chk("glitch_next_good", int'(o_good[1]), 2);

    // Line low through reset release, then high, then 0x0F.
    rxv[0] = 1'b0;
    rxv[1] = 1'b0;
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    hold(1, 1'b0, 200);
    rxv[0] = 1'b1;
    hold(1, 1'b1, 5);
    frame(1, 8'h0F, 1'b1);
    hold(1, 1'b1, 20);
    chk("lowrst_good", int'(o_good[1]), 1);
    chk("lowrst_data", int'(o_data[1]), 8'h0F);

    // Reset in the middle of data bit 4, then a continuous 0xAA stream.
    hold(1, 1'b0, CPB1);
    for (int i = 0; i < 4; i++) hold(1, i[0], CPB1);
    hold(1, 1'b0, CPB1 / 2);
    rxv[1] = 1'b1;
    rst = 1'b1;
    step(1);
    chk("midrst_good_cleared", int'(o_good[1]), 0);
    chk("midrst_data_cleared", int'(o_data[1]), 0);
    step(1);
    rst = 1'b0;
    vq1.delete();
    hold(1, 1'b1, 2);
    fall = cyc;
    repeat (3) frame(1, 8'hAA, 1'b1);
    hold(1, 1'b1, 20);
    chk("midrst_pulses", vq1.size(), 3);
    chk("midrst_good", int'(o_good[1]), 3);
    chk("midrst_err", int'(o_err[1]), 0);
    if (vq1.size() == 3) begin
      chk("midrst_lat", vq1[0] - fall, 153 + SL);
      chk("midrst_spacing", vq1[1] - vq1[0], 160);
    end

    // Randomized traffic on both instances; the model checks every cycle.
    fork
      rand_traffic(0, 60);
      rand_traffic(1, 12);
    join

    // Error counter saturation.
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    hold(0, 1'b1, 2);
    repeat (260) begin
      frame(0, 8'h33, 1'b0);
      hold(0, 1'b1, 1);
    end
    hold(0, 1'b1, 3 + SL);
    chk("sat_err_cnt", int'(o_err[0]), 255);
    chk("sat_good_cnt", int'(o_good[0]), 0);
    frame(0, 8'hC3, 1'b1);
    hold(0, 1'b1, 3 + SL);
    chk("sat_then_good", int'(o_good[0]), 1);
    chk("sat_then_data", int'(o_data[0]), 8'hC3);
    chk("sat_err_hold", int'(o_err[0]), 255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx_checker.md
Name: uart_rx_checker

Overview:
- Downstream consumer of the cycled UART transmitter line. Deserialises 1 start (0) + 8 data (LSB first) + 1 stop (1) frames from a single-bit serial input.
- Presents each received byte with a one-cycle valid pulse and flags framing errors.
- Keeps saturating good-frame and error counters for board-level link checking.
- Must accept back-to-back frames with zero idle between the stop bit and the next start bit.

Parameters:
- CLKS_PER_BIT, 1, clk cycles per serial bit (≥1); 1 matches the one-bit-per-clk transmitter.
- HALF, CLKS_PER_BIT/2 (integer division), sample offset within a bit; derived (localparam), not overridable.

Ports:
- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- rx  in  1  serial line, idle high
- data  out  8  last received byte, held until the next valid frame
- valid  out  1  one-cycle pulse, data updated this cycle
- frame_err  out  1  one-cycle pulse, stop bit sampled 0
- good_cnt  out  16  count of valid frames, saturates at 16'hFFFF
- err_cnt  out  8  count of framing errors, saturates at 8'hFF

Behaviour:
- Reset values:
  - data=0, valid=0, frame_err=0, good_cnt=0, err_cnt=0
  - state=IDLE, bit cnt=0, cycle cnt=0
  - rx_prev=0: after reset the line must be seen high before any start is accepted.
- rx_prev <= rx every cycle, in every state.
- Cycle counter runs 0..CLKS_PER_BIT-1 within each bit:
  - rx is sampled at cnt==HALF.
  - The state advances at cnt==CLKS_PER_BIT-1.
- IDLE:
  - Start detect condition: rx==0 && rx_prev==1. This cycle is cycle 0 of the start bit.
  - If HALF==0: start is confirmed immediately; go to DATA with cnt=0, bit=0.
  - Otherwise: go to START with cnt=1.
- START:
  - At cnt==HALF, rx==1 is a false start: go to IDLE with no pulses and no counter change.
  - Otherwise, at the end of the bit go to DATA.
- DATA:
  - At cnt==HALF, shift rx into shift[bit] (LSB first).
  - After bit 7 ends, go to STOP.
- STOP, at cnt==HALF:
  - rx==1: data<=shift, valid=1, good_cnt+1 (saturating).
  - rx==0: frame_err=1, err_cnt+1 (saturating), data unchanged.
  - In both cases go to IDLE at the end of the bit. When HALF==CLKS_PER_BIT-1 this is the same cycle.
- Outputs are registered: valid/frame_err assert in the cycle after the stop-bit sample edge.
- Latency from the start-bit falling edge on rx to valid = 9*CLKS_PER_BIT + HALF + 1 cycles.
- Back-to-back frames: IDLE is reached by the last cycle of the stop bit, so a start bit immediately following is detected (rx_prev=1 from stop). With CLKS_PER_BIT=1, valid pulses every 10 cycles.
- Framing error recovery: return to IDLE and wait for the next 1→0 edge. There is no extra hunt delay.
- Saturation: a counter at max holds; no wrap.
- valid and frame_err are never both high.
- rst mid-frame: the partial frame is discarded, all outputs are cleared next cycle, and no pulse is emitted for that frame.

Optional Feature:
- Macro: UART_RX_SYNC_EN
- Defined:
  - rx passes through a 2-flop synchronizer (flops reset to 1) before all logic.
  - All latencies increase by exactly 2 cycles.
  - Makes rx safe for an asynchronous/off-board source.
- Undefined: rx is used directly. The same-clock-domain transmitter is assumed; there is no added latency.

Test Plan:
- Continuous frames of 0xAA, CLKS_PER_BIT=1, rx idle high after rst → valid every 10 cycles, data=8'hAA, frame_err never asserts, good_cnt=3 after 3 frames.
- CLKS_PER_BIT=16, single frame 0x5A then idle → one valid pulse at 9*16+8+1=153 cycles after the falling edge, data=8'h5A.
- CLKS_PER_BIT=16, frame 0x3C with stop bit forced 0 → frame_err pulse, err_cnt=1, data keeps its previous value, valid stays 0.
- CLKS_PER_BIT=16, rx low for 4 cycles then high (glitch) → false start rejected: no pulses, counters unchanged, next good frame 0x81 received correctly.
- rx held low through rst release, then high 5 cycles, then frame 0x0F → no start accepted while low; 0x0F received, good_cnt=1.
- rst asserted during DATA bit 4, then released with continuous 0xAA stream → outputs cleared, no pulse for the aborted frame; subsequent frames counted (with UART_RX_SYNC_EN, check the +2 cycle shift).
